// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared FSM state type, NOP encoding and PC increment helper for fetch_unit
package fetch_pkg;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        WAIT   = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    // ADD R0,R0,R0
    localparam logic [15:0] NOP_INSTR = 16'h0000;

    function automatic logic [15:0] pc_inc(input logic [15:0] pc);
        return pc + 16'd2;
    endfunction

endpackage

// File: rtl/fetch_dff.sv
// rtl/fetch_dff.sv - generic enabled D flip-flop cell with synchronous reset value
module fetch_dff #(
    parameter int          W       = 16,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_en,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_q <= RST_VAL;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/fetch_pc_reg.sv
// rtl/fetch_pc_reg.sv - 16-bit program counter register with write enable, reset to RESET_PC
module fetch_pc_reg #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_wen,
    input  logic [15:0] i_d,
    output logic [15:0] o_pc
);

    fetch_dff #(
        .W       (16),
        .RST_VAL (RESET_PC)
    ) u_pc_dff (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_en  (i_wen),
        .i_d   (i_d),
        .o_q   (o_pc)
    );

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage feeding IF_ID; optional wait counter under FETCH_PERF_CNT_EN
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_in,
    input  logic        flush_in,
    input  logic        branch_taken_in,
    input  logic [15:0] branch_addr_in,
    input  logic        hlt_in,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ready,
    input  logic [15:0] imem_rdata,
    output logic [15:0] PC_current_out,
    output logic [15:0] PC_plus_2_out,
    output logic [15:0] instr_out,
    output logic        instr_valid_out,
    output logic        halted_out
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0] imem_wait_cnt_out
`endif
);

    fetch_state_t r_state, w_state_nxt;

    logic [15:0] w_pc, w_pc_d;
    logic        w_pc_wen;
    logic        w_req;
    logic        w_deliver;
    logic [15:0] w_word;

    logic        r_pend_valid, w_pend_valid_nxt;
    logic [15:0] r_pend_data, w_pend_data_nxt;
    logic [15:0] r_instr, w_instr_nxt;
    logic [15:0] r_pc_cur, w_pc_cur_nxt;
    logic [15:0] r_pc_p2, w_pc_p2_nxt;
    logic        r_valid, w_valid_nxt;

    fetch_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .i_clk (clk),
        .i_rst (rst),
        .i_wen (w_pc_wen),
        .i_d   (w_pc_d),
        .o_pc  (w_pc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_pc_wen         = 1'b0;
        w_pc_d           = pc_inc(w_pc);
        w_req            = 1'b0;
        w_deliver        = 1'b0;
        w_word           = imem_rdata;
        w_pend_valid_nxt = r_pend_valid;
        w_pend_data_nxt  = r_pend_data;
        w_instr_nxt      = r_instr;
        w_pc_cur_nxt     = r_pc_cur;
        w_pc_p2_nxt      = r_pc_p2;
        w_valid_nxt      = r_valid;

        if (!rst && r_state != HALTED) begin
            if (branch_taken_in) begin
                w_pc_wen         = 1'b1;
                w_pc_d           = {branch_addr_in[15:1], 1'b0};
                w_pend_valid_nxt = 1'b0;
                w_instr_nxt      = NOP_INSTR;
                w_valid_nxt      = 1'b0;
                w_state_nxt      = FETCH;
            end else if (hlt_in) begin
                w_pend_valid_nxt = 1'b0;
                w_instr_nxt      = NOP_INSTR;
                w_valid_nxt      = 1'b0;
                w_state_nxt      = HALTED;
            end else if (r_state == WAIT && r_pend_valid) begin
                // Word already parked during a stall; release it once the stall drops.
                if (!stall_in) begin
                    w_deliver = 1'b1;
                    w_word    = r_pend_data;
                end
            end else begin
                // An outstanding request in WAIT stays on the bus even under stall.
                w_req = (r_state == WAIT) || !stall_in;
                if (w_req && imem_ready) begin
                    if (stall_in) begin
                        w_pend_valid_nxt = 1'b1;
                        w_pend_data_nxt  = imem_rdata;
                    end else begin
                        w_deliver = 1'b1;
                    end
                end else if (w_req) begin
                    w_instr_nxt = NOP_INSTR;
                    w_valid_nxt = 1'b0;
                    w_state_nxt = WAIT;
                end
            end

            if (w_deliver) begin
                w_pc_wen         = 1'b1;
                w_pend_valid_nxt = 1'b0;
                w_instr_nxt      = flush_in ? NOP_INSTR : w_word;
                w_valid_nxt      = !flush_in;
                w_pc_cur_nxt     = w_pc;
                w_pc_p2_nxt      = pc_inc(w_pc);
                w_state_nxt      = FETCH;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend_valid <= 1'b0;
            r_pend_data  <= NOP_INSTR;
            r_instr      <= NOP_INSTR;
            r_pc_cur     <= RESET_PC;
            r_pc_p2      <= pc_inc(RESET_PC);
            r_valid      <= 1'b0;
        end else begin
            r_pend_valid <= w_pend_valid_nxt;
            r_pend_data  <= w_pend_data_nxt;
            r_instr      <= w_instr_nxt;
            r_pc_cur     <= w_pc_cur_nxt;
            r_pc_p2      <= w_pc_p2_nxt;
            r_valid      <= w_valid_nxt;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] r_wait_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait_cnt <= 16'h0000;
        end else if (w_req && !imem_ready && r_wait_cnt != 16'hFFFF) begin
            r_wait_cnt <= r_wait_cnt + 16'd1;
        end
    end

    assign imem_wait_cnt_out = r_wait_cnt;
`endif

    assign imem_req        = w_req;
    assign imem_addr       = w_pc;
    assign PC_current_out  = r_pc_cur;
    assign PC_plus_2_out   = r_pc_p2;
    assign instr_out       = r_instr;
    assign instr_valid_out = r_valid;
    assign halted_out      = (r_state == HALTED);

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit (wait counter checked when FETCH_PERF_CNT_EN is defined)
module tb_fetch_unit;

    localparam logic [15:0] NOP = 16'h0000;

    logic        clk = 1'b0;
    logic        rst, stall_in, flush_in, branch_taken_in, hlt_in, imem_ready;
    logic [15:0] branch_addr_in;
    logic        imem_req;
    logic [15:0] imem_addr, imem_rdata;
    logic [15:0] PC_current_out, PC_plus_2_out, instr_out;
    logic        instr_valid_out, halted_out;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] imem_wait_cnt_out;
`endif

    typedef struct {
        logic [15:0] instr;
        logic [15:0] pc;
        logic [15:0] pc2;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    logic [15:0] pc;

    function automatic logic [15:0] word(input logic [15:0] a);
        return a ^ 16'hBEEF;
    endfunction

    assign imem_rdata = word(imem_addr);

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(16'h0000)) dut (
        .clk             (clk),
        .rst             (rst),
        .stall_in        (stall_in),
        .flush_in        (flush_in),
        .branch_taken_in (branch_taken_in),
        .branch_addr_in  (branch_addr_in),
        .hlt_in          (hlt_in),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ready      (imem_ready),
        .imem_rdata      (imem_rdata),
        .PC_current_out  (PC_current_out),
        .PC_plus_2_out   (PC_plus_2_out),
        .instr_out       (instr_out),
        .instr_valid_out (instr_valid_out),
        .halted_out      (halted_out)
`ifdef FETCH_PERF_CNT_EN
        ,
        .imem_wait_cnt_out (imem_wait_cnt_out)
`endif
    );

    function automatic void push_exp(input logic [15:0] a);
        exp_t e;
        e.instr = word(a);
        e.pc    = a;
        e.pc2   = a + 16'd2;
        sb.push_back(e);
    endfunction

    task automatic tick(input logic exp_valid);
        exp_t e;
        @(posedge clk);
        #1;
        checks++;
        if (instr_valid_out !== exp_valid) begin
            errors++;
            $display("FAIL valid got=%b exp=%b t=%0t", instr_valid_out, exp_valid, $time);
        end else if (exp_valid) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_empty got instr=%h pc=%h", instr_out, PC_current_out);
            end else begin
                e = sb.pop_front();
                if (instr_out !== e.instr || PC_current_out !== e.pc || PC_plus_2_out !== e.pc2) begin
                    errors++;
                    $display("FAIL sb_data got=%h/%h/%h exp=%h/%h/%h", instr_out, PC_current_out,
                             PC_plus_2_out, e.instr, e.pc, e.pc2);
                end
            end
        end else begin
            checks++;
            if (instr_out !== NOP) begin
                errors++;
                $display("FAIL nop_instr got=%h exp=%h", instr_out, NOP);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; stall_in = 1'b0; flush_in = 1'b0; branch_taken_in = 1'b0;
        branch_addr_in = 16'h0000; hlt_in = 1'b0; imem_ready = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got=%b exp=0", imem_req); end
        tick(1'b0);
        tick(1'b0);
        checks++;
        if (PC_current_out !== 16'h0000 || PC_plus_2_out !== 16'h0002 || halted_out !== 1'b0) begin
            errors++;
            $display("FAIL rst_state got pc=%h pc2=%h halt=%b exp 0000/0002/0", PC_current_out, PC_plus_2_out, halted_out);
        end
        rst = 1'b0;
        pc  = 16'h0000;
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
            errors++;
            $display("FAIL rst_release got req=%b addr=%h exp 1/0000", imem_req, imem_addr);
        end
    endtask

    task automatic test_zero_wait();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (imem_addr !== pc) begin errors++; $display("FAIL zw_addr got=%h exp=%h", imem_addr, pc); end
            push_exp(pc);
            tick(1'b1);
            pc = pc + 16'd2;
        end
    endtask

    task automatic test_wait();
        while (pc != 16'h0010) begin
            push_exp(pc);
            tick(1'b1);
            pc = pc + 16'd2;
        end
        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== 16'h0010) begin
                errors++;
                $display("FAIL wait_hold got req=%b addr=%h exp 1/0010", imem_req, imem_addr);
            end
            tick(1'b0);
        end
`ifdef FETCH_PERF_CNT_EN
        checks++;
        if (imem_wait_cnt_out !== 16'd3) begin
            errors++;
            $display("FAIL wait_cnt got=%0d exp=3", imem_wait_cnt_out);
        end
`endif
        imem_ready = 1'b1;
        push_exp(pc);
        tick(1'b1);
        pc = 16'h0012;
        #1;
        checks++;
        if (imem_addr !== 16'h0012) begin errors++; $display("FAIL wait_next got=%h exp=0012", imem_addr); end
    endtask

    task automatic test_branch();
        imem_ready = 1'b0;
        tick(1'b0);
        tick(1'b0);
        branch_taken_in = 1'b1; branch_addr_in = 16'h1235; imem_ready = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b0) begin errors++; $display("FAIL br_req got=%b exp=0", imem_req); end
        tick(1'b0);
        branch_taken_in = 1'b0;
        pc = 16'h1234;
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h1234) begin
            errors++;
            $display("FAIL br_target got req=%b addr=%h exp 1/1234", imem_req, imem_addr);
        end
        push_exp(pc);
        tick(1'b1);
        pc = pc + 16'd2;
    endtask

    task automatic test_stall_wait();
        imem_ready = 1'b0;
        tick(1'b0);
        stall_in = 1'b1; imem_ready = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b1) begin errors++; $display("FAIL sw_req got=%b exp=1", imem_req); end
        tick(1'b0);
        #1;
        checks++;
        if (imem_req !== 1'b0) begin errors++; $display("FAIL sw_parked_req got=%b exp=0", imem_req); end
        tick(1'b0);
        stall_in = 1'b0; imem_ready = 1'b0;
        push_exp(pc);
        tick(1'b1);
        pc = pc + 16'd2;
        imem_ready = 1'b1;
        push_exp(pc);
        tick(1'b1);
        pc = pc + 16'd2;
    endtask

    task automatic test_stall_flush();
        stall_in = 1'b1;
        push_exp(pc - 16'd2);
        #1;
        checks++;
        if (imem_req !== 1'b0) begin errors++; $display("FAIL st_req got=%b exp=0", imem_req); end
        tick(1'b1);
        stall_in = 1'b0; flush_in = 1'b1;
        tick(1'b0);
        flush_in = 1'b0;
        pc = pc + 16'd2;
        #1;
        checks++;
        if (imem_addr !== pc) begin errors++; $display("FAIL flush_adv got=%h exp=%h", imem_addr, pc); end
    endtask

    task automatic test_wrap();
        branch_taken_in = 1'b1; branch_addr_in = 16'hFFFF;
        tick(1'b0);
        branch_taken_in = 1'b0;
        pc = 16'hFFFE;
        push_exp(pc);
        tick(1'b1);
        #1;
        checks++;
        if (imem_addr !== 16'h0000) begin errors++; $display("FAIL wrap_addr got=%h exp=0000", imem_addr); end
    endtask

    task automatic test_halt();
        branch_taken_in = 1'b1; branch_addr_in = 16'h0040;
        tick(1'b0);
        branch_taken_in = 1'b0;
        hlt_in = 1'b1;
        #1;
        checks++;
        if (imem_addr !== 16'h0040 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL hlt_req got req=%b addr=%h exp 0/0040", imem_req, imem_addr);
        end
        tick(1'b0);
        hlt_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (halted_out !== 1'b1 || imem_req !== 1'b0) begin
                errors++;
                $display("FAIL halted got halt=%b req=%b exp 1/0", halted_out, imem_req);
            end
            tick(1'b0);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b0) begin errors++; $display("FAIL hlt_rst_req got=%b exp=0", imem_req); end
        tick(1'b0);
        checks++;
        if (halted_out !== 1'b0 || PC_current_out !== 16'h0000) begin
            errors++;
            $display("FAIL hlt_rst got halt=%b pc=%h exp 0/0000", halted_out, PC_current_out);
        end
        rst = 1'b0;
        pc = 16'h0000;
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
            errors++;
            $display("FAIL hlt_resume got req=%b addr=%h exp 1/0000", imem_req, imem_addr);
        end
        push_exp(pc);
        tick(1'b1);
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait();
        test_branch();
        test_stall_wait();
        test_stall_flush();
        test_wrap();
        test_halt();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover got=%0d exp=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
